// File: rtl/cr16_fetch_pkg.sv
// Shared state encoding and sizing constants for the CR16 instruction fetch stage.
package cr16_fetch_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} fetch_state_t;

    localparam int C_MAX_MEM_LATENCY = 4;
    localparam int C_CNT_W           = $clog2(C_MAX_MEM_LATENCY);

endpackage

// File: rtl/fetch_latency_counter.sv
// Load/decrement down counter that flags when the memory latency window has elapsed.
module fetch_latency_counter
    import cr16_fetch_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [C_CNT_W-1:0] load_value_i,
    input  logic               dec_i,
    output logic               zero_o
);

    logic [C_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_value_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// CR16 instruction fetch: one memory read per request, fixed latency plus wait stalls.
// Optional stall-cycle counter port enabled by defining CR16_FETCH_STALL_COUNT_EN.
module instr_fetch
    import cr16_fetch_pkg::*;
#(
    parameter int P_ADDRESS_WIDTH = 16,
    parameter int P_DATA_WIDTH    = 16,
    parameter int P_MEM_LATENCY   = 1
) (
    input  logic                       I_CLK,
    input  logic                       I_NRESET,
    input  logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS,
    input  logic                       I_FETCH,
    input  logic                       I_FLUSH,
    input  logic                       I_ACCEPT,
    output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
    output logic                       O_MEM_READ,
    input  logic [P_DATA_WIDTH-1:0]    I_MEM_DATA,
    input  logic                       I_MEM_WAIT,
    output logic [P_DATA_WIDTH-1:0]    O_INSTRUCTION,
    output logic                       O_VALID,
    output logic                       O_PC_ENABLE,
    output logic                       O_BUSY
`ifdef CR16_FETCH_STALL_COUNT_EN
   ,output logic [15:0]                O_STALL_CYCLES
`endif
);

    localparam logic [C_CNT_W-1:0] C_LOAD = C_CNT_W'(P_MEM_LATENCY - 1);

    fetch_state_t                 state_q, state_d;
    logic [P_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [P_DATA_WIDTH-1:0]      instr_q, instr_d;
    logic                         valid_q, valid_d;
    logic                         pcen_q, pcen_d;
    logic                         cnt_load, cnt_dec, cnt_zero;

    fetch_latency_counter u_lat_cnt (
        .clk_i        (I_CLK),
        .rst_ni       (I_NRESET),
        .load_i       (cnt_load),
        .load_value_i (C_LOAD),
        .dec_i        (cnt_dec),
        .zero_o       (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        pcen_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A flush (branch redirect) also suppresses a fetch of the stale PC.
                if (!I_FLUSH && I_FETCH) begin
                    addr_d  = I_ADDRESS;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (I_FLUSH) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (I_FLUSH) begin
                    state_d = S_IDLE;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (!I_MEM_WAIT) begin
                    instr_d = I_MEM_DATA;
                    valid_d = 1'b1;
                    pcen_d  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (I_FLUSH) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (I_ACCEPT) begin
                    valid_d = 1'b0;
                    if (I_FETCH) begin
                        addr_d  = I_ADDRESS;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            pcen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pcen_q  <= pcen_d;
        end
    end

    assign O_MEM_ADDRESS = addr_q;
    assign O_MEM_READ    = (state_q == S_ISSUE);
    assign O_INSTRUCTION = instr_q;
    assign O_VALID       = valid_q;
    assign O_PC_ENABLE   = pcen_q;
    assign O_BUSY        = (state_q != S_IDLE);

`ifdef CR16_FETCH_STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    // Counts memory-wait cycles once the fixed latency has elapsed, saturating.
    always_comb begin
        stall_d = stall_q;
        if (state_q == S_WAIT && cnt_zero && I_MEM_WAIT && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign O_STALL_CYCLES = stall_q;
`else
    // No stall statistics in this build.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (latency 1 and 3) driven in parallel, checked
// against a timestamp-based transaction model plus literal expectations.
module tb_instr_fetch;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] addr = '0;
  logic          fetch = 1'b0, flush = 1'b0, accept = 1'b0, mwait = 1'b0;
  logic [DW-1:0] mdata = '0;

  logic [AW-1:0] mem_addr [2];
  logic          mem_read [2];
  logic [DW-1:0] instr    [2];
  logic          valid    [2];
  logic          pc_en    [2];
  logic          busy     [2];
  logic [15:0]   stall    [2];

  int tests = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  instr_fetch #(.P_ADDRESS_WIDTH(AW), .P_DATA_WIDTH(DW), .P_MEM_LATENCY(1)) u_dut0 (
    .I_CLK(clk), .I_NRESET(rst_n), .I_ADDRESS(addr), .I_FETCH(fetch), .I_FLUSH(flush),
    .I_ACCEPT(accept), .O_MEM_ADDRESS(mem_addr[0]), .O_MEM_READ(mem_read[0]),
    .I_MEM_DATA(mdata), .I_MEM_WAIT(mwait), .O_INSTRUCTION(instr[0]), .O_VALID(valid[0]),
    .O_PC_ENABLE(pc_en[0]), .O_BUSY(busy[0])
`ifdef CR16_FETCH_STALL_COUNT_EN
   ,.O_STALL_CYCLES(stall[0])
`endif
  );

  instr_fetch #(.P_ADDRESS_WIDTH(AW), .P_DATA_WIDTH(DW), .P_MEM_LATENCY(3)) u_dut1 (
    .I_CLK(clk), .I_NRESET(rst_n), .I_ADDRESS(addr), .I_FETCH(fetch), .I_FLUSH(flush),
    .I_ACCEPT(accept), .O_MEM_ADDRESS(mem_addr[1]), .O_MEM_READ(mem_read[1]),
    .I_MEM_DATA(mdata), .I_MEM_WAIT(mwait), .O_INSTRUCTION(instr[1]), .O_VALID(valid[1]),
    .O_PC_ENABLE(pc_en[1]), .O_BUSY(busy[1])
`ifdef CR16_FETCH_STALL_COUNT_EN
   ,.O_STALL_CYCLES(stall[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Transaction model: a fetch becomes a read strobe one cycle later; data is due once
  // L cycles have passed since the strobe, and each waited cycle after that slips capture.
  int            n = 0;
  bit            pend [2]  = '{0, 0};
  bit            held [2]  = '{0, 0};
  int            t_iss [2] = '{-1, -1};
  int            t_pc [2]  = '{-1, -1};
  logic [AW-1:0] e_addr [2] = '{16'h0, 16'h0};
  logic [DW-1:0] e_ins [2]  = '{16'h0, 16'h0};
  int            e_stl [2]  = '{0, 0};

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      for (int k = 0; k < 2; k++) begin
        pend[k] = 0; held[k] = 0; t_iss[k] = -1; t_pc[k] = -1;
        e_addr[k] = '0; e_ins[k] = '0; e_stl[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit due;
        bit start;
        due   = pend[k] && (n > t_iss[k]) && ((n - t_iss[k]) >= lat(k));
        start = 0;
        if (due && mwait && e_stl[k] < 65535) e_stl[k]++;
        if (flush) begin
          pend[k] = 0;
          held[k] = 0;
        end else if (pend[k]) begin
          if (due && !mwait) begin
            held[k] = 1; pend[k] = 0; e_ins[k] = mdata; t_pc[k] = n + 1;
          end
        end else if (held[k]) begin
          if (accept) begin
            held[k] = 0;
            start = fetch;
          end
        end else begin
          start = fetch;
        end
        if (start) begin
          e_addr[k] = addr; pend[k] = 1; t_iss[k] = n + 1;
        end
      end
      n++;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m%0d.mem_read", k), 32'(mem_read[k]), 32'(pend[k] && n == t_iss[k]));
      chk($sformatf("m%0d.mem_addr", k), 32'(mem_addr[k]), 32'(e_addr[k]));
      chk($sformatf("m%0d.valid", k),    32'(valid[k]),    32'(held[k]));
      chk($sformatf("m%0d.instr", k),    32'(instr[k]),    32'(e_ins[k]));
      chk($sformatf("m%0d.pc_en", k),    32'(pc_en[k]),    32'(n == t_pc[k]));
      chk($sformatf("m%0d.busy", k),     32'(busy[k]),     32'(pend[k] || held[k]));
`ifdef CR16_FETCH_STALL_COUNT_EN
      chk($sformatf("m%0d.stall", k),    32'(stall[k]),    32'(e_stl[k]));
`endif
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    // cycle 0
    chk("rst.valid", 32'(valid[0]), 0);
    chk("rst.busy", 32'(busy[1]), 0);
    addr = 16'h0040; fetch = 1'b1; mdata = 16'hA5C3;
    nxt(); // cycle 1
    fetch = 1'b0;
    chk("l1.mem_read", 32'(mem_read[0]), 1);
    chk("l1.mem_addr", 32'(mem_addr[0]), 32'h0040);
    chk("l3.mem_read", 32'(mem_read[1]), 1);
    nxt(); // cycle 2
    chk("l1.valid_c2", 32'(valid[0]), 0);
    nxt(); // cycle 3
    chk("l1.valid_c3", 32'(valid[0]), 1);
    chk("l1.instr_c3", 32'(instr[0]), 32'hA5C3);
    chk("l1.pcen_c3", 32'(pc_en[0]), 1);
    nxt(); // cycle 4
    chk("l1.pcen_c4", 32'(pc_en[0]), 0);
    mwait = 1'b1;
    nxt(); // cycle 5
    nxt(); // cycle 6
    mwait = 1'b0;
    chk("l3.valid_c6", 32'(valid[1]), 0);
    nxt(); // cycle 7
    chk("l3.valid_c7", 32'(valid[1]), 1);
    chk("l3.instr_c7", 32'(instr[1]), 32'hA5C3);
    chk("l3.pcen_c7", 32'(pc_en[1]), 1);
`ifdef CR16_FETCH_STALL_COUNT_EN
    chk("l3.stall", 32'(stall[1]), 2);
    chk("l1.stall", 32'(stall[0]), 0);
`endif
    accept = 1'b1; fetch = 1'b1; addr = 16'h0041; mdata = 16'h1234;
    nxt(); // cycle 8
    accept = 1'b0; fetch = 1'b0;
    chk("b2b.mem_read", 32'(mem_read[0]), 1);
    chk("b2b.mem_addr", 32'(mem_addr[1]), 32'h0041);
    chk("b2b.valid", 32'(valid[1]), 0);
    repeat (4) nxt(); // cycle 12
    chk("b2b.instr0", 32'(instr[0]), 32'h1234);
    chk("b2b.instr1", 32'(instr[1]), 32'h1234);
    accept = 1'b1; fetch = 1'b1; addr = 16'h0050; mdata = 16'hBEEF;
    nxt(); // cycle 13
    accept = 1'b0; fetch = 1'b0;
    nxt(); // cycle 14
    flush = 1'b1;
    nxt(); // cycle 15
    flush = 1'b0;
    chk("fl.valid0", 32'(valid[0]), 0);
    chk("fl.busy1", 32'(busy[1]), 0);
    chk("fl.pcen0", 32'(pc_en[0]), 0);
    chk("fl.instr0", 32'(instr[0]), 32'h1234);
    nxt(); // cycle 16
    chk("fl.pcen0_late", 32'(pc_en[0]), 0);
    fetch = 1'b1; addr = 16'h0060; mdata = 16'h5A5A;
    nxt(); // cycle 17
    fetch = 1'b0;
    repeat (4) nxt(); // cycle 21
    chk("fa.valid1_pre", 32'(valid[1]), 1);
    flush = 1'b1; accept = 1'b1; fetch = 1'b1; addr = 16'h0070;
    nxt(); // cycle 22
    flush = 1'b0; accept = 1'b0; fetch = 1'b0;
    chk("fa.valid1", 32'(valid[1]), 0);
    chk("fa.busy0", 32'(busy[0]), 0);
    chk("fa.mem_read1", 32'(mem_read[1]), 0);
    chk("fa.instr1", 32'(instr[1]), 32'h5A5A);
    fetch = 1'b1; addr = 16'h0080;
    nxt(); // cycle 23
    fetch = 1'b0;
    nxt(); // cycle 24: latency-3 instance is waiting
    rst_n = 1'b0;
    #1;
    chk("rw.valid", 32'(valid[1]), 0);
    chk("rw.mem_read", 32'(mem_read[1]), 0);
    chk("rw.instr", 32'(instr[1]), 0);
    chk("rw.busy", 32'(busy[1]), 0);
    nxt();
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      fetch  = 1'($urandom_range(0, 1));
      accept = 1'($urandom_range(0, 1));
      flush  = ($urandom_range(0, 15) == 0);
      mwait  = ($urandom_range(0, 3) == 0);
      addr   = 16'($urandom);
      mdata  = 16'($urandom);
      nxt();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
